// File: rtl/alu_issue_ctrl_if.sv
// Issue/writeback bus between the instruction source, register loader, debug port,
// the external combinational ALU and the issue controller.
interface alu_issue_ctrl_if #(
    parameter int unsigned DW = 32
);
    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instr;
    logic          ld_valid;
    logic [2:0]    ld_addr;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          done;
    logic [2:0]    done_rd;
    logic [DW-1:0] done_result;
    logic          zero_flag;
    logic          illegal;
    logic [2:0]    dbg_addr;
    logic [DW-1:0] dbg_data;

    modport master (
        output instr_valid, instr, ld_valid, ld_addr, ld_data, alu_result, alu_zero, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op, done, done_rd, done_result, zero_flag,
        input  illegal, dbg_data
    );

    modport slave (
        input  instr_valid, instr, ld_valid, ld_addr, ld_data, alu_result, alu_zero, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op, done, done_rd, done_result, zero_flag,
        output illegal, dbg_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller around a combinational ALU: fixed IDLE -> EXEC -> WB sequence,
// 8-entry register file with direct load port and combinational debug read.
module alu_issue_ctrl #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned DW    = 32
) (
    input logic             clk,
    input logic             rst_n,
    alu_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e        state_q, state_d;
    logic [15:0]   instr_q;
    logic [DW-1:0] res_q;
    logic          zq_q;
    logic [2:0]    rd_q;
    logic          zero_flag_q;
    logic          illegal_q;
    logic [DW-1:0] regs_q [NREGS];
    logic          accept;

    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic       op_legal;
    logic       wb_we;

    assign op  = instr_q[15:12];
    assign rd  = instr_q[11:9];
    assign rs1 = instr_q[8:6];
    assign rs2 = instr_q[5:3];

    assign op_legal = op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111};
    assign wb_we    = (state_q == StWb) && op_legal && (rd != 3'd0);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.instr_valid) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            instr_q     <= '0;
            res_q       <= '0;
            zq_q        <= 1'b0;
            rd_q        <= '0;
            zero_flag_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q <= bus.instr;
            end
            // Operands are consumed here, so loads landing on this edge are not seen.
            if (state_q == StExec) begin
                res_q <= bus.alu_result;
                zq_q  <= bus.alu_zero;
                rd_q  <= rd;
            end
            if (state_q == StWb) begin
                if (op_legal) begin
                    zero_flag_q <= zq_q;
                end else begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    // Writeback is assigned after the load so it wins a same-register collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (bus.ld_valid && (bus.ld_addr != 3'd0)) begin
                regs_q[bus.ld_addr] <= bus.ld_data;
            end
            if (wb_we) begin
                regs_q[rd] <= res_q;
            end
        end
    end

    logic exec;
    assign exec = (state_q == StExec);

    assign bus.instr_ready = rst_n && (state_q == StIdle);
    assign bus.alu_op      = exec ? op : 4'd0;
    assign bus.alu_a       = (exec && rs1 != 3'd0) ? regs_q[rs1] : '0;
    assign bus.alu_b       = (exec && rs2 != 3'd0) ? regs_q[rs2] : '0;
    assign bus.done        = (state_q == StWb);
    assign bus.done_rd     = rd_q;
    assign bus.done_result = res_q;
    assign bus.zero_flag   = zero_flag_q;
    assign bus.illegal     = illegal_q;
    assign bus.dbg_data    = (bus.dbg_addr == 3'd0) ? '0 : regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed literal checks plus randomized traffic compared every
// cycle against a transaction-level model of the controller.
module tb_alu_issue_ctrl;

    logic clk;
    logic rst_n;

    alu_issue_ctrl_if #(.DW(32)) bus ();

    alu_issue_ctrl #(.NREGS(8), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return (op <= 4'd4) || (op == 4'd6) || (op == 4'd7);
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    // External ALU stand-in
    logic [31:0] alu_res_w;
    assign alu_res_w      = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_result = alu_res_w;
    assign bus.alu_zero   = (alu_res_w == 32'd0);

    int n_cmp = 0;
    int n_err = 0;
    int dn_cnt = 0;
    bit chk_on = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted instruction computes its result at the accept edge,
    // shows done one cycle after the next edge, and commits two edges after acceptance.
    logic [31:0] m_regs [8];
    int          edge_n = 0;
    bit          pend = 0;
    int          p_edge = 0;
    logic [3:0]  p_op;
    logic [2:0]  p_rd;
    logic [31:0] p_a, p_b, p_res;
    logic [2:0]  m_done_rd = '0;
    logic [31:0] m_done_res = '0;
    logic        m_zf = 1'b0;
    logic        m_ill = 1'b0;

    task automatic model_step();
        bit can_acc;
        logic [2:0] s1, s2;
        edge_n++;
        can_acc = !pend;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            pend = 0; m_done_rd = '0; m_done_res = '0; m_zf = 1'b0; m_ill = 1'b0;
            return;
        end
        if (pend && edge_n == p_edge + 1) begin
            m_done_rd  = p_rd;
            m_done_res = p_res;
        end
        if (bus.ld_valid && bus.ld_addr != 3'd0) m_regs[bus.ld_addr] = bus.ld_data;
        if (pend && edge_n == p_edge + 2) begin
            if (is_legal(p_op)) begin
                if (p_rd != 3'd0) m_regs[p_rd] = p_res;
                m_zf = (p_res == 32'd0);
            end else begin
                m_ill = 1'b1;
            end
            pend = 0;
        end
        if (can_acc && bus.instr_valid) begin
            p_op  = bus.instr[15:12];
            p_rd  = bus.instr[11:9];
            s1    = bus.instr[8:6];
            s2    = bus.instr[5:3];
            p_a   = (s1 == 3'd0) ? 32'd0 : m_regs[s1];
            p_b   = (s2 == 3'd0) ? 32'd0 : m_regs[s2];
            p_res = alu_fn(p_op, p_a, p_b);
            pend  = 1;
            p_edge = edge_n;
        end
    endtask

    task automatic compare_all();
        bit in_exec, in_wb;
        logic [31:0] exp_dbg;
        in_exec = pend && (edge_n == p_edge);
        in_wb   = pend && (edge_n == p_edge + 1);
        exp_dbg = (bus.dbg_addr == 3'd0) ? 32'd0 : m_regs[bus.dbg_addr];
        if (bus.done === 1'b1) dn_cnt++;
        check("instr_ready", 32'(bus.instr_ready), 32'(rst_n && !pend));
        check("done", 32'(bus.done), 32'(in_wb));
        check("done_rd", 32'(bus.done_rd), 32'(m_done_rd));
        check("done_result", bus.done_result, m_done_res);
        check("zero_flag", 32'(bus.zero_flag), 32'(m_zf));
        check("illegal", 32'(bus.illegal), 32'(m_ill));
        check("alu_op", 32'(bus.alu_op), in_exec ? 32'(p_op) : 32'd0);
        check("alu_a", bus.alu_a, in_exec ? p_a : 32'd0);
        check("alu_b", bus.alu_b, in_exec ? p_b : 32'd0);
        check("dbg_data", bus.dbg_data, exp_dbg);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            chk_on = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) compare_all();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        step();
        bus.ld_valid = 1'b0;
    endtask

    task automatic peek(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus.dbg_addr = a;
        @(negedge clk);
        check(name, bus.dbg_data, exp);
        step();
    endtask

    // Issue one instruction from IDLE, check the WB cycle, optionally load during WB.
    task automatic issue_chk(input string name, input logic [15:0] ins, input logic [2:0] rd,
                             input logic [31:0] res, input bit wb_ld, input logic [2:0] la,
                             input logic [31:0] ldat);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        step();
        bus.instr_valid = 1'b0;
        step();
        @(negedge clk);
        check({name, "_done"}, 32'(bus.done), 32'd1);
        check({name, "_rd"}, 32'(bus.done_rd), 32'(rd));
        check({name, "_res"}, bus.done_result, res);
        if (wb_ld) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = la;
            bus.ld_data  = ldat;
        end
        step();
        bus.ld_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'($urandom_range(0, 40));
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dn0;
        logic [3:0] legal_ops [7];
        legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};

        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.dbg_addr    = '0;
        repeat (2) step();
        rst_n = 1'b1;

        @(negedge clk);
        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        step();
        for (int a = 0; a < 8; a++) peek("rst_reg", 3'(a), 32'd0);

        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        issue_chk("add", 16'h0650, 3'd3, 32'd8, 0, 3'd0, 32'd0);
        peek("add_r3", 3'd3, 32'd8);
        check("add_zf", 32'(bus.zero_flag), 32'd0);

        issue_chk("sub0", mk(4'd1, 3'd4, 3'd1, 3'd1), 3'd4, 32'd0, 0, 3'd0, 32'd0);
        check("sub0_zf", 32'(bus.zero_flag), 32'd1);
        issue_chk("subneg", mk(4'd1, 3'd5, 3'd2, 3'd1), 3'd5, 32'hFFFF_FFFE, 0, 3'd0, 32'd0);
        check("subneg_zf", 32'(bus.zero_flag), 32'd0);

        load(3'd2, 32'd33);
        issue_chk("sll_r0", mk(4'd6, 3'd0, 3'd1, 3'd2), 3'd0, 32'd10, 0, 3'd0, 32'd0);
        peek("sll_r0_dbg", 3'd0, 32'd0);
        check("sll_r0_zf", 32'(bus.zero_flag), 32'd0);

        issue_chk("ill", mk(4'b1010, 3'd6, 3'd1, 3'd2), 3'd6, 32'd0, 0, 3'd0, 32'd0);
        check("ill_flag", 32'(bus.illegal), 32'd1);
        check("ill_zf", 32'(bus.zero_flag), 32'd0);
        peek("ill_r6", 3'd6, 32'd0);
        issue_chk("after_ill", mk(4'd0, 3'd7, 3'd1, 3'd2), 3'd7, 32'd38, 0, 3'd0, 32'd0);
        check("ill_sticky", 32'(bus.illegal), 32'd1);

        load(3'd2, 32'd3);
        issue_chk("wb_vs_ld", 16'h0650, 3'd3, 32'd8, 1, 3'd3, 32'hDEAD);
        peek("wb_wins", 3'd3, 32'd8);

        dn0 = dn_cnt;
        bus.instr_valid = 1'b1;
        bus.instr       = mk(4'd0, 3'd7, 3'd1, 3'd2);
        repeat (6) step();
        bus.instr_valid = 1'b0;
        repeat (4) step();
        check("hold_accepts", 32'(dn_cnt - dn0), 32'd2);

        dn0 = dn_cnt;
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h0650;
        step();
        bus.instr_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("rst_exec_nodone", 32'(dn_cnt - dn0), 32'd0);
        for (int a = 0; a < 8; a++) peek("rst_exec_reg", 3'(a), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            bus.instr_valid = 1'($urandom_range(0, 1));
            bus.instr = {($urandom_range(0, 7) == 0) ? 4'($urandom) :
                         legal_ops[$urandom_range(0, 6)], 12'($urandom)};
            bus.ld_valid = ($urandom_range(0, 2) == 0);
            bus.ld_addr  = 3'($urandom);
            bus.ld_data  = rnd_data();
            bus.dbg_addr = 3'($urandom);
            step();
        end
        rst_n = 1'b1;
        bus.instr_valid = 1'b0;
        bus.ld_valid    = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
